// File: rtl/rand_mt32_untemper.sv
// Inverse of the MT32 tempering transform. Each inverse xor-shift step is
// solved by fixed-point iteration X <= Y ^ f(X), one iteration per clock.
module rand_mt32_untemper #(
  parameter logic [31:0] C_B = 32'h9D2C5680,
  parameter logic [31:0] C_C = 32'hEFC60000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic [31:0] oData,
  output logic        oValid,
  input  logic        iReady
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_y;
  logic [31:0] r_x;
  logic [31:0] r_data;
  logic [1:0]  r_stage;
  logic [2:0]  r_iter;
  logic [31:0] w_x_nxt;
  logic        w_last;

  // Steps are undone in reverse tempering order: >>18, <<15, <<7, >>11.
  function automatic logic [31:0] f_step(input logic [1:0] stage, input logic [31:0] x);
    case (stage)
      2'd0:    f_step = x >> 18;
      2'd1:    f_step = (x << 15) & C_C;
      2'd2:    f_step = (x << 7) & C_B;
      default: f_step = x >> 11;
    endcase
  endfunction

  // ceil(32/shift) iterations reach the fixed point for each step.
  function automatic logic [2:0] f_iters(input logic [1:0] stage);
    case (stage)
      2'd0:    f_iters = 3'd2;
      2'd1:    f_iters = 3'd3;
      2'd2:    f_iters = 3'd5;
      default: f_iters = 3'd3;
    endcase
  endfunction

  assign w_x_nxt = r_y ^ f_step(r_stage, r_x);
  assign w_last  = (r_iter == (f_iters(r_stage) - 3'd1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iValid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last && (r_stage == 2'd3)) w_state_nxt = S_DONE;
      S_DONE:  if (iReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oReady = 1'b0;
    oValid = 1'b0;
    case (r_state)
      S_IDLE:  oReady = 1'b1;
      S_DONE:  oValid = 1'b1;
      default: ;
    endcase
  end

  assign oData = r_data;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_y     <= '0;
      r_x     <= '0;
      r_data  <= '0;
      r_stage <= '0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iValid) begin
            r_y     <= iData;
            r_x     <= iData;
            r_stage <= '0;
            r_iter  <= '0;
          end
        end
        S_RUN: begin
          r_x <= w_x_nxt;
          if (w_last) begin
            r_iter <= '0;
            // Final stage publishes the result; earlier stages seed the next Y.
            if (r_stage == 2'd3) begin
              r_data <= w_x_nxt;
            end else begin
              r_y     <= w_x_nxt;
              r_stage <= r_stage + 2'd1;
            end
          end else begin
            r_iter <= r_iter + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
